// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin scheduler time-sharing one free-running sequential multiplier among N requesters
module mult_share_ctrl #(
  parameter int M = 12,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*M-1:0] a_in,
  input  logic [N*M-1:0] b_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [2*M-1:0] result,
  output logic [M-1:0]   mult_a,
  output logic [M-1:0]   mult_b,
  input  logic [2*M-1:0] mult_p,
  input  logic           mult_update
);
  localparam int W = $clog2(N);
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  state_t state, state_d;
  logic [W-1:0] ptr, ptr_d, g, g_d, g_nxt, pick, idx;
  logic [N-1:0] gnt_d, done_d;
  logic [2*M-1:0] result_d;
  logic [M-1:0] a_d, b_d;
  logic upd_q, e;
  assign e = mult_update & ~upd_q;
  assign g_nxt = (int'(g) == N - 1) ? '0 : g + 1'b1;
  always_comb begin
    pick = ptr;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = W'((int'(ptr) + k) % N);
      if (req[idx]) pick = idx;
    end
  end
  always_comb begin
    state_d = state;
    ptr_d = ptr;
    g_d = g;
    gnt_d = gnt;
    done_d = '0;
    result_d = result;
    a_d = mult_a;
    b_d = mult_b;
    case (state)
      IDLE: if (|req) begin
        state_d = ARM;
        g_d = pick;
        gnt_d = N'(1) << pick;
        a_d = a_in[int'(pick)*M +: M];
        b_d = b_in[int'(pick)*M +: M];
      end
      // the first completion after grant came from the old operands; only RUN may capture
      ARM, RUN: if (!req[g] || (e && state == RUN)) begin
        state_d = IDLE;
        gnt_d = '0;
        ptr_d = g_nxt;
        if (req[g]) begin
          result_d = mult_p;
          done_d = gnt;
        end
      end else if (e) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      g <= '0;
      gnt <= '0;
      done <= '0;
      result <= '0;
      mult_a <= '0;
      mult_b <= '0;
      upd_q <= 1'b0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      g <= g_d;
      gnt <= gnt_d;
      done <= done_d;
      result <= result_d;
      mult_a <= a_d;
      mult_b <= b_d;
      upd_q <= mult_update;
    end
endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: directed and randomized checks of mult_share_ctrl against a free-running multiplier model
module tb_mult_share_ctrl;
  localparam int M = 12, N = 4, P = M + 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*M-1:0] a_in = '0, b_in = '0;
  logic [N-1:0] gnt, done;
  logic [2*M-1:0] result, mult_p = '0;
  logic [M-1:0] mult_a, mult_b, opa = '0, opb = '0;
  logic mult_update = 1'b0;
  int cnt = 0, nvec = 0, nmis = 0, rr = 0;
  always #5 clk = ~clk;
  mult_share_ctrl #(.M(M), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .result(result), .mult_a(mult_a), .mult_b(mult_b),
    .mult_p(mult_p), .mult_update(mult_update)
  );
  // multiplier: loads operands while its flag is high, delivers that product one period later
  always @(posedge clk) begin
    cnt <= (cnt == P - 1) ? 0 : cnt + 1;
    mult_update <= (cnt == P - 1);
    if (cnt == P - 1) mult_p <= opa * opb;
    if (cnt == 0) begin
      opa <= mult_a;
      opb <= mult_b;
    end
  end
  function automatic int rr_pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    nvec++;
    assert (obs === want) else begin
      nmis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask
  task automatic randomize_ops();
    for (int i = 0; i < N; i++) begin
      a_in[i*M +: M] = M'($urandom);
      b_in[i*M +: M] = M'($urandom);
    end
  endtask
  // call in IDLE with req already set; returns on the done cycle
  task automatic serve(input logic scramble, input logic drop, output int lat);
    int g;
    logic bad;
    logic [2*M-1:0] want;
    g = rr_pick(req, rr);
    want = a_in[g*M +: M] * b_in[g*M +: M];
    @(negedge clk);
    chk("grant", gnt, N'(1) << g);
    chk("done_idle", done, 0);
    if (scramble) randomize_ops();
    bad = 1'b0;
    lat = 0;
    while (done === '0 && lat < 2*P + 4) begin
      if (gnt !== N'(1) << g) bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("done_idx", done, N'(1) << g);
    chk("result", result, want);
    chk("gnt_drop", gnt, 0);
    chk("gnt_hold", bad, 0);
    chk("latency_range", (lat > P && lat <= 2*P + 1), 1);
    rr = (g + 1) % N;
    if (drop) req[g] = 1'b0;
  endtask
  task automatic wait_run();
    int n;
    n = 0;
    while (mult_update !== 1'b1 && n < 2*P) begin
      @(negedge clk);
      n++;
    end
    chk("arm_event_seen", n < 2*P, 1);
    repeat (3) @(negedge clk);
  endtask
  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    rst_n = 1'b1;
    @(negedge clk);
    a_in[0 +: M] = 3; b_in[0 +: M] = 5; req = 4'b0001;
    serve(0, 1, lat);
    chk("single_3x5", result, 15);
    a_in[M +: M] = 4095; b_in[M +: M] = 4095; req = 4'b0010;
    serve(0, 1, lat);
    chk("max_operands", result, 16769025);
    a_in[3*M +: M] = 0; b_in[3*M +: M] = 4095; req = 4'b1000;
    serve(0, 1, lat);
    chk("zero_operand", result, 0);
    for (int i = 0; i < N; i++) begin
      a_in[i*M +: M] = M'(i + 1);
      b_in[i*M +: M] = M'(i + 2);
    end
    req = '1;
    for (int k = 0; k < 5; k++) begin
      serve(0, 0, lat);
      chk("rr_done_order", done, N'(1) << (k % N));
      chk("rr_result", result, (k % N + 1) * (k % N + 2));
    end
    req = '0;
    a_in[M +: M] = 10; b_in[M +: M] = 11; req = 4'b0010;
    serve(1, 1, lat);
    chk("operand_change", result, 110);
    a_in[2*M +: M] = 50; b_in[2*M +: M] = 60;
    a_in[3*M +: M] = 13; b_in[3*M +: M] = 17;
    req = 4'b1100;
    @(negedge clk);
    chk("abort_grant", gnt, 4'b0100);
    wait_run();
    req[2] = 1'b0;
    @(negedge clk);
    chk("abort_gnt_clear", gnt, 0);
    chk("abort_no_done", done, 0);
    chk("abort_result_kept", result, 110);
    rr = 3;
    serve(0, 1, lat);
    chk("after_abort_result", result, 221);
    a_in[M +: M] = 20; b_in[M +: M] = 30; req = 4'b0010;
    @(negedge clk);
    chk("pre_reset_grant", gnt, 4'b0010);
    wait_run();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", gnt, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_result", result, 0);
    chk("async_rst_mult_a", mult_a, 0);
    chk("async_rst_mult_b", mult_b, 0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    rr = 0;
    a_in[0 +: M] = 7; b_in[0 +: M] = 9; req = 4'b0001;
    serve(0, 1, lat);
    chk("post_reset_7x9", result, 63);
    a_in[M +: M] = 100; b_in[M +: M] = 200;
    for (int n = 0; n < P && cnt != P - 2; n++) @(negedge clk);
    req = 4'b0010;
    serve(0, 1, lat);
    chk("stale_guard_result", result, 20000);
    chk("stale_guard_latency", lat, 17);
    for (int t = 0; t < 16; t++) begin
      randomize_ops();
      repeat ($urandom_range(0, P - 1)) @(negedge clk);
      req = N'($urandom_range(1, (1 << N) - 1));
      serve(1, 0, lat);
      req = '0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Round-robin scheduler that time-shares one free-running radix-2 sequential multiplier (operand width M, result 2M, completion flag `update`) among N requesters in the FILTER datapath. It grants one requester at a time and holds that requester's operands stable on the multiplier. It discards the stale result of the multiplier pass already in flight, captures the first result computed entirely from the granted operands, and returns that result with a one-cycle done pulse.

## Interface
- `M`, 12, operand width (must match multiplier `m`)
- `N`, 4, number of requesters (2..8)
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  N  request per requester; level, held until `done` or abort
- `a_in`  in  N*M  operand A of requester i at bits [i*M +: M], unsigned
- `b_in`  in  N*M  operand B of requester i at bits [i*M +: M], unsigned
- `gnt`  out  N  one-hot grant, high for the whole operation
- `done`  out  N  one-cycle pulse on bit of the served requester
- `result`  out  2M  product of served requester, valid with `done`, held until next `done`
- `mult_a`, `mult_b`  out  M  operands to the multiplier, registered
- `mult_p`  in  2M  multiplier product output
- `mult_update`  in  1  multiplier completion flag

## Operation
- Reset values: `gnt`=0, `done`=0, `result`=0, `mult_a`=0, `mult_b`=0, state IDLE, RR pointer=0, `upd_q`=0.
- Edge detect: `upd_q` <= `mult_update` each cycle. Event E = `mult_update & ~upd_q`.
- States:
  - IDLE: if any `req`, pick the first set bit searching from pointer `ptr` upward with wrap. Set the `gnt` bit, latch that requester's `a_in`/`b_in` into `mult_a`/`mult_b`, go to ARM. Otherwise stay.
  - ARM: wait for E. That result came from operands loaded before the grant, so discard it and go to RUN.
  - RUN: on E, capture `mult_p` into `result`, pulse `done[g]`, clear `gnt`, set `ptr` = g+1 mod N, go to IDLE.
- Operands are sampled once, at grant. Changing `a_in`/`b_in` during an operation has no effect.
- Abort: if `req[g]` falls while in ARM or RUN, clear `gnt` next cycle and return to IDLE. No `done`, `result` unchanged, `ptr` = g+1 mod N.
- A new grant is never issued in the same cycle as a `done`. IDLE always lasts at least one cycle.
- Arithmetic: unsigned M×M into 2M. `result` is a direct copy of `mult_p`, with no truncation or sign handling.
- Fairness: a continuously requesting requester is served within N operations.
- Async reset mid-operation: everything returns to reset values immediately. A multiplier pass in flight is ignored and the next grant starts with ARM as usual.

## Timing
- Multiplier period P = M+3 cycles between E events (15 for M=12).
- Grant latency: `req` rising in IDLE gives `gnt` on the next edge.
- Operation latency, from `gnt` high to `done`: more than P and at most 2P+1 cycles.
- `done` and `result` update on the same edge. `gnt` falls on that edge.
- Back-to-back throughput: one product per 2 to 3 multiplier periods. This is deliberate; ARM must not be skipped.
- E arriving in the same cycle as an abort: the abort wins.

## Test plan
- Single op, M=12, N=4: `req[0]`, a=3, b=5 → `gnt`=0001 in 1 cycle, `done`=0001 within 31 cycles, `result`=15, and `result` ≠ any stale `mult_p`.
- Max operands: a=b=4095 → `result`=16769025. Then a=0, b=4095 → `result`=0.
- Round-robin: `req`=1111 held, distinct operands (i+1)*(i+2) → `done` order 0,1,2,3,0; each `result` matches its own requester; no cycle with two `gnt` bits set.
- Operand change and abort: change `a_in[1]` after grant → product uses the original value. Drop `req[2]` during RUN → no `done[2]`, `gnt` clears in 1 cycle, next grant goes to 3.
- Reset mid-op: assert `rst_n`=0 during RUN → all outputs 0 asynchronously. After release, a=7, b=9 → `result`=63.
- Stale-result guard: grant in the cycle just before E → that E is discarded and `done` arrives one period later with the correct product.
